// File: rtl/inst_fetch_buffer_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package : ibuf_pkg                                                       |
// | Shared types and constants for the three-wide instruction fetch buffer:  |
// | lane count, legal fetch-valid patterns, the default-width entry record   |
// | and a helper that turns a lane count into a contiguous valid mask.       |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
package ibuf_pkg;

    localparam int IBUF_LANES = 3;
    localparam int IBUF_XLEN  = 32;

    // Legal fetch_valid_i patterns (contiguous prefixes only)
    localparam logic [2:0] FV_NONE  = 3'b000;
    localparam logic [2:0] FV_ONE   = 3'b001;
    localparam logic [2:0] FV_TWO   = 3'b011;
    localparam logic [2:0] FV_THREE = 3'b111;

    // One buffer entry at the default data width
    typedef struct packed {
        logic [IBUF_XLEN-1:0] pc;
        logic [IBUF_XLEN-1:0] instruction;
        logic [IBUF_XLEN-1:0] imm;
        logic                 pred;
    } ibuf_entry_t;

    // Lane count (0..3) to contiguous lane-valid mask
    function automatic logic [2:0] prefix_mask(input logic [1:0] n);
        case (n)
            2'd0:    return FV_NONE;
            2'd1:    return FV_ONE;
            2'd2:    return FV_TWO;
            default: return FV_THREE;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/inst_fetch_buffer_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Interface : inst_fetch_buffer_if                                         |
// | Bundles the fetch-side enqueue handshake, the three decode lanes, the    |
// | flush request and the occupancy report of inst_fetch_buffer.             |
// |   master : fetch/decode environment (drives fetch lanes, decode ready,   |
// |            flush; observes ready, decode lanes, occupancy)               |
// |   slave  : the buffer itself                                             |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
interface inst_fetch_buffer_if #(
    parameter int size  = 32,
    parameter int DEPTH = 16
);

    logic                    flush;

    logic [2:0]              fetch_valid_i;
    logic                    fetch_ready_o;
    logic [size-1:0]         fetch_pc_i_0, fetch_pc_i_1, fetch_pc_i_2;
    logic [size-1:0]         fetch_instruction_i_0, fetch_instruction_i_1, fetch_instruction_i_2;
    logic [size-1:0]         fetch_imm_i_0, fetch_imm_i_1, fetch_imm_i_2;
    logic                    fetch_pred_i_0, fetch_pred_i_1, fetch_pred_i_2;

    logic [2:0]              decode_valid_o;
    logic [2:0]              decode_ready_i;
    logic [size-1:0]         decode_pc_o_0, decode_pc_o_1, decode_pc_o_2;
    logic [size-1:0]         decode_instruction_o_0, decode_instruction_o_1, decode_instruction_o_2;
    logic [size-1:0]         decode_imm_o_0, decode_imm_o_1, decode_imm_o_2;
    logic                    decode_pred_o_0, decode_pred_o_1, decode_pred_o_2;

    logic [$clog2(DEPTH):0]  occupancy_o;

    modport master (
        output flush,
        output fetch_valid_i,
        input  fetch_ready_o,
        output fetch_pc_i_0, fetch_pc_i_1, fetch_pc_i_2,
        output fetch_instruction_i_0, fetch_instruction_i_1, fetch_instruction_i_2,
        output fetch_imm_i_0, fetch_imm_i_1, fetch_imm_i_2,
        output fetch_pred_i_0, fetch_pred_i_1, fetch_pred_i_2,
        input  decode_valid_o,
        output decode_ready_i,
        input  decode_pc_o_0, decode_pc_o_1, decode_pc_o_2,
        input  decode_instruction_o_0, decode_instruction_o_1, decode_instruction_o_2,
        input  decode_imm_o_0, decode_imm_o_1, decode_imm_o_2,
        input  decode_pred_o_0, decode_pred_o_1, decode_pred_o_2,
        input  occupancy_o
    );

    modport slave (
        input  flush,
        input  fetch_valid_i,
        output fetch_ready_o,
        input  fetch_pc_i_0, fetch_pc_i_1, fetch_pc_i_2,
        input  fetch_instruction_i_0, fetch_instruction_i_1, fetch_instruction_i_2,
        input  fetch_imm_i_0, fetch_imm_i_1, fetch_imm_i_2,
        input  fetch_pred_i_0, fetch_pred_i_1, fetch_pred_i_2,
        output decode_valid_o,
        input  decode_ready_i,
        output decode_pc_o_0, decode_pc_o_1, decode_pc_o_2,
        output decode_instruction_o_0, decode_instruction_o_1, decode_instruction_o_2,
        output decode_imm_o_0, decode_imm_o_1, decode_imm_o_2,
        output decode_pred_o_0, decode_pred_o_1, decode_pred_o_2,
        output occupancy_o
    );

endinterface
`default_nettype wire

// File: rtl/ibuf_prefix_count.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : ibuf_prefix_count                                               |
// | Counts the leading ones of a 3-bit lane vector starting at bit 0.        |
// | Bits after the first zero are ignored, so 101 counts as 1.               |
// |   vec_i   [2:0] : lane vector                                            |
// |   count_o [1:0] : number of contiguous ones from lane 0 (0..3)           |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module ibuf_prefix_count (
    input  wire logic [2:0] vec_i,
    output logic      [1:0] count_o
);

    always_comb begin
        count_o = 2'd0;
        if (vec_i[0]) begin
            count_o = 2'd1;
            if (vec_i[1]) begin
                count_o = 2'd2;
                if (vec_i[2]) begin
                    count_o = 2'd3;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/inst_fetch_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : inst_fetch_buffer                                               |
// | Three-wide circular instruction buffer between superscalar fetch and the |
// | three decode lanes. Accepts up to three in-order entries per cycle and   |
// | presents the three oldest entries to decode; single-cycle flush.         |
// |   clk   : rising-edge clock                                              |
// |   reset : asynchronous active-high reset                                 |
// |   bus   : inst_fetch_buffer_if.slave (fetch lanes, decode lanes, flush,  |
// |           occupancy)                                                     |
// | Parameters: size (data width), DEPTH (power of two, >= 4)                |
// | Build option: IBUF_BYPASS_EN - when the buffer is empty, fetch lanes are |
// |   forwarded combinationally to decode and only unconsumed lanes stored.  |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module inst_fetch_buffer
    import ibuf_pkg::*;
#(
    parameter int size  = 32,
    parameter int DEPTH = 16
) (
    input  wire logic          clk,
    input  wire logic          reset,
    inst_fetch_buffer_if.slave bus
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // Entry layout matches ibuf_entry_t but follows the size parameter
    typedef struct packed {
        logic [size-1:0] pc;
        logic [size-1:0] instruction;
        logic [size-1:0] imm;
        logic            pred;
    } entry_t;

    // Storage is deliberately left out of reset
    entry_t          mem_q [DEPTH];

    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;

    logic            w_fetch_ready;
    logic            w_bypass;
    logic [2:0]      w_fetch_valid_eff;
    logic [2:0]      w_dec_valid;
    logic [2:0]      w_dec_fire;
    logic [1:0]      w_n_in;
    logic [1:0]      w_n_out;
    entry_t          w_fetch_entry [IBUF_LANES];
    entry_t          w_dec_entry   [IBUF_LANES];
    logic [IBUF_LANES-1:0] w_wr_en;
    logic [PW-1:0]   w_wr_idx [IBUF_LANES];

    // ---------------------------------------------------------------
    // Fetch side
    // ---------------------------------------------------------------
    assign w_fetch_entry[0] = '{pc: bus.fetch_pc_i_0, instruction: bus.fetch_instruction_i_0,
                                imm: bus.fetch_imm_i_0, pred: bus.fetch_pred_i_0};
    assign w_fetch_entry[1] = '{pc: bus.fetch_pc_i_1, instruction: bus.fetch_instruction_i_1,
                                imm: bus.fetch_imm_i_1, pred: bus.fetch_pred_i_1};
    assign w_fetch_entry[2] = '{pc: bus.fetch_pc_i_2, instruction: bus.fetch_instruction_i_2,
                                imm: bus.fetch_imm_i_2, pred: bus.fetch_pred_i_2};

    // Room for a full 3-wide group; depends on registered count only so
    // fetch never sees a combinational path from decode.
    assign w_fetch_ready     = (count_q <= CW'(DEPTH - 3));
    assign w_fetch_valid_eff = (w_fetch_ready && !bus.flush) ? bus.fetch_valid_i : FV_NONE;

    ibuf_prefix_count u_n_in (
        .vec_i   (w_fetch_valid_eff),
        .count_o (w_n_in)
    );

`ifdef IBUF_BYPASS_EN
    assign w_bypass = (count_q == '0) && !bus.flush;
`else
    assign w_bypass = 1'b0;
`endif

    // ---------------------------------------------------------------
    // Decode side: oldest entries, or the incoming lanes when bypassing
    // ---------------------------------------------------------------
    always_comb begin
        w_dec_valid = FV_NONE;
        for (int k = 0; k < IBUF_LANES; k++) begin
            w_dec_entry[k] = '0;
        end
        if (w_bypass) begin
            w_dec_valid = prefix_mask(w_n_in);
            for (int k = 0; k < IBUF_LANES; k++) begin
                if (w_dec_valid[k]) begin
                    w_dec_entry[k] = w_fetch_entry[k];
                end
            end
        end else begin
            for (int k = 0; k < IBUF_LANES; k++) begin
                if (count_q > CW'(k)) begin
                    w_dec_valid[k] = 1'b1;
                    w_dec_entry[k] = mem_q[head_q + PW'(k)];
                end
            end
        end
    end

    assign w_dec_fire = w_dec_valid & bus.decode_ready_i;

    ibuf_prefix_count u_n_out (
        .vec_i   (w_dec_fire),
        .count_o (w_n_out)
    );

    // ---------------------------------------------------------------
    // Write steering. In bypass the first n_out lanes go straight to
    // decode, so the remaining lanes are packed down to start at tail.
    // ---------------------------------------------------------------
    always_comb begin
        for (int k = 0; k < IBUF_LANES; k++) begin
            w_wr_en[k]  = 1'b0;
            w_wr_idx[k] = tail_q + PW'(k);
            if (w_bypass) begin
                w_wr_en[k]  = (2'(k) < w_n_in) && (2'(k) >= w_n_out);
                w_wr_idx[k] = tail_q + PW'(k) - PW'(w_n_out);
            end else begin
                w_wr_en[k]  = (2'(k) < w_n_in);
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < IBUF_LANES; k++) begin
            if (w_wr_en[k]) begin
                mem_q[w_wr_idx[k]] <= w_fetch_entry[k];
            end
        end
    end

    // ---------------------------------------------------------------
    // Pointer / count update; flush overrides everything
    // ---------------------------------------------------------------
    always_comb begin
        count_d = count_q + CW'(w_n_in) - CW'(w_n_out);
        if (w_bypass) begin
            // Head already equals tail; consumed lanes never occupy a slot
            head_d = head_q;
            tail_d = tail_q + PW'(w_n_in) - PW'(w_n_out);
        end else begin
            head_d = head_q + PW'(w_n_out);
            tail_d = tail_q + PW'(w_n_in);
        end
        if (bus.flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // ---------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------
    assign bus.fetch_ready_o          = w_fetch_ready;
    assign bus.decode_valid_o         = w_dec_valid;
    assign bus.occupancy_o            = count_q;

    assign bus.decode_pc_o_0          = w_dec_entry[0].pc;
    assign bus.decode_pc_o_1          = w_dec_entry[1].pc;
    assign bus.decode_pc_o_2          = w_dec_entry[2].pc;
    assign bus.decode_instruction_o_0 = w_dec_entry[0].instruction;
    assign bus.decode_instruction_o_1 = w_dec_entry[1].instruction;
    assign bus.decode_instruction_o_2 = w_dec_entry[2].instruction;
    assign bus.decode_imm_o_0         = w_dec_entry[0].imm;
    assign bus.decode_imm_o_1         = w_dec_entry[1].imm;
    assign bus.decode_imm_o_2         = w_dec_entry[2].imm;
    assign bus.decode_pred_o_0        = w_dec_entry[0].pred;
    assign bus.decode_pred_o_1        = w_dec_entry[1].pred;
    assign bus.decode_pred_o_2        = w_dec_entry[2].pred;

endmodule
`default_nettype wire

// File: doc/inst_fetch_buffer.md
# inst_fetch_buffer

Three-wide circular instruction buffer between the superscalar fetch stage and the three decode lanes. It is the consumer end of the fetch-side `fetch_valid`/`fetch_ready` interface. Each cycle it accepts up to three in-order instructions, with their PC, early immediate and branch-prediction bit, and presents up to three oldest entries to decode. It absorbs fetch/decode rate mismatch and supports a single-cycle flush on misprediction.

## Interface
Parameters:
- `size`, 32: data width of PC, instruction and immediate.
- `DEPTH`, 16: number of entries. Must be a power of two and ≥ 4.

Ports:
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `flush` in 1: synchronous clear of all entries.
- `fetch_valid_i` in 3: per-lane enqueue valid. Only the patterns 000, 001, 011 and 111 are legal.
- `fetch_ready_o` out 1: buffer can accept 3 entries this cycle.
- `fetch_pc_i_0/_1/_2` in size each: lane PCs.
- `fetch_instruction_i_0/_1/_2` in size each: lane instructions.
- `fetch_imm_i_0/_1/_2` in size each: lane immediates.
- `fetch_pred_i_0/_1/_2` in 1 each: lane predicted-taken bits.
- `decode_valid_o` out 3: per-lane output valid, always a contiguous prefix.
- `decode_ready_i` in 3: per-lane decode accept.
- `decode_pc_o_0/_1/_2`, `decode_instruction_o_0/_1/_2`, `decode_imm_o_0/_1/_2` out size each: output lanes.
- `decode_pred_o_0/_1/_2` out 1 each: output lane prediction bits.
- `occupancy_o` out $clog2(DEPTH)+1: current entry count.

## Operation
- Storage is DEPTH entries of {pc, instruction, imm, pred}. It has a head (read) pointer, a tail (write) pointer, each $clog2(DEPTH) bits and wrapping modulo DEPTH, plus a count register.
- `fetch_ready_o` = (count ≤ DEPTH−3). It is combinational from registered count only and never depends on `decode_ready_i`.
- Enqueue number n_in:
  - equals the number of leading ones of `fetch_valid_i`, when `fetch_ready_o` = 1 and `flush` = 0;
  - is 0 otherwise.
- Lane k is written to slot (tail+k) mod DEPTH, and tail advances by n_in.
- Output lane k shows slot (head+k) mod DEPTH. `decode_valid_o[k]` = (count > k).
- Invalid output lanes drive all-zero data.
- Dequeue number n_out = leading-ones count of (`decode_valid_o` & `decode_ready_i`). Non-prefix ready bits are ignored. head advances by n_out.
- Next count = count + n_in − n_out. Simultaneous enqueue and dequeue are allowed in the same cycle.
- Flush has priority over everything: head, tail and count go to 0, and that cycle's enqueue and dequeue are discarded.
- Illegal `fetch_valid_i` patterns such as 101 enqueue only the leading prefix (here 1 entry).

## Timing
- Reset values:
  - pointers and count: 0
  - `fetch_ready_o`: 1
  - `decode_valid_o`: 000
  - all decode data: 0
  - `occupancy_o`: 0
- Reset asserted mid-operation clears the buffer immediately. Storage RAM contents are not reset.
- Enqueue-to-decode latency is 1 cycle: data written at edge N is visible on the decode outputs after edge N.
- After flush at edge N: `decode_valid_o` = 000 and `fetch_ready_o` = 1 from edge N onward.
- Full boundary: at count = DEPTH−2, `fetch_ready_o` = 0 even if decode dequeues 3 that cycle. Ready returns on the following cycle.
- Empty boundary: at count 0 all valids are low; `decode_ready_i` has no effect.
- Wrap-around: a 3-wide write or read that straddles slot DEPTH−1 to slot 0 is handled in one cycle.

## Configuration
- `IBUF_BYPASS_EN` defined: when count = 0 and `flush` = 0, fetch lanes are forwarded combinationally to the decode outputs in the same cycle.
  - `decode_valid_o` = the `fetch_valid_i` prefix.
  - Lanes consumed by decode are not written.
  - Unconsumed lanes are written starting at tail.
  - The `fetch_ready_o` rule is unchanged.
- `IBUF_BYPASS_EN` undefined: the 1-cycle latency above always applies.

## Structure
- Package `ibuf_pkg`:
  - `ibuf_entry_t` packed struct {pc, instruction, imm, pred}
  - `IBUF_LANES` = 3
  - the legal fetch-valid pattern constants
- One sub-module, `ibuf_prefix_count`: a 3-bit vector in, leading-ones count (0–3) out. It is instantiated twice, once for n_in and once for n_out.

## Test plan
- **Reset/basic:** release reset, enqueue 111 with PCs 0x0/0x4/0x8 → next cycle `decode_valid_o` = 111 with matching PCs and `occupancy_o` = 3.
- **Partial dequeue:** 3 entries present, `decode_ready_i` = 101 → only lane 0 dequeued, next cycle head PC = 0x4 and `occupancy_o` = 2.
- **Full:** fill to 14 with DEPTH = 16 → `fetch_ready_o` = 0. Enqueue 111 with 111 dequeue → occupancy 11, and ready = 1 next cycle.
- **Wrap:** cycle 20 enqueue/dequeue rounds of 3 with DEPTH = 16 → PCs emerge strictly in order 0x0, 0x4, … with no gaps or duplicates.
- **Flush collision:** flush together with enqueue 111 and dequeue 111 → next cycle occupancy 0, `decode_valid_o` = 000, ready = 1.
- **Bypass (`IBUF_BYPASS_EN`):** empty buffer, enqueue 011 with ready 001 → same cycle lane 0 out; next cycle occupancy 1 holding the lane-1 PC.
